// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit : multi-cycle MIPS fetch stage (PC, imem handshake, next-PC select)
// Revision   : 1.0
// ============================================================================
module fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0040_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  imem_ready,
    input  logic                  Jump,
    input  logic                  BranchEQ,
    input  logic                  BranchNE,
    input  logic                  Zero,
    input  logic                  stall,
    output logic [DATA_WIDTH-1:0] Instruction,
    output logic [5:0]            OP,
    output logic [DATA_WIDTH-1:0] PC,
    output logic [DATA_WIDTH-1:0] PC_4,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] retired_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [DATA_WIDTH-1:0] retired_q, retired_d;

    logic [DATA_WIDTH-1:0] pc4_w;
    logic [DATA_WIDTH-1:0] jump_tgt_w;
    logic [DATA_WIDTH-1:0] br_off_w;
    logic [DATA_WIDTH-1:0] next_pc_w;
    logic                  br_taken_w;

    assign pc4_w      = pc_q + DATA_WIDTH'(4);
    assign jump_tgt_w = {pc4_w[DATA_WIDTH-1:28], instr_q[25:0], 2'b00};
    assign br_off_w   = {{(DATA_WIDTH-18){instr_q[15]}}, instr_q[15:0], 2'b00};
    assign br_taken_w = (BranchEQ & Zero) | (BranchNE & ~Zero);

    // Jump has priority over any taken branch.
    always_comb begin
        next_pc_w = pc4_w;
        if (Jump) begin
            next_pc_w = jump_tgt_w;
        end else if (br_taken_w) begin
            next_pc_w = pc4_w + br_off_w;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        retired_d   = retired_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                instr_valid = 1'b1;
                if (!stall) begin
                    pc_d      = next_pc_w;
                    retired_d = retired_q + DATA_WIDTH'(1);
                    state_d   = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign imem_addr   = pc_q;
    assign Instruction = instr_q;
    assign OP          = instr_q[31:26];
    assign PC          = pc_q;
    assign PC_4        = pc4_w;
    assign retired_cnt = retired_q;

endmodule
`default_nettype wire
